id_ex_stage: RTL and testbench

- The ID/EX pipeline stage sits directly upstream of the ALU.
- It registers the decoded instruction from ID, resolves operand forwarding from EX/MEM and MEM/WB, and selects the immediate.
- It drives the ALU's op1, op2 and operation inputs, and carries the control fields forward for the EX/MEM register.
- It also detects load-use hazards and inserts bubbles into EX.

---
 rtl/pipeline_pkg.sv | 29 ++
 rtl/id_ex_stage_fwd_mux.sv | 26 ++
 rtl/id_ex_stage.sv | 149 ++++++++++++++
 tb/tb_id_ex_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: datapath widths, ALU operation codes and the
// field values loaded into a stage register when a bubble is inserted.
package pipeline_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned OP_W       = 6;

  typedef enum logic [5:0] {
    ALU_ADD = 6'd0,
    ALU_SUB = 6'd1,
    ALU_MUL = 6'd2,
    ALU_DIV = 6'd3,
    ALU_SLL = 6'd4,
    ALU_SRL = 6'd5,
    ALU_SLT = 6'd6,
    ALU_AND = 6'd7,
    ALU_OR  = 6'd8,
    ALU_XOR = 6'd9,
    ALU_NOR = 6'd10,
    ALU_SRA = 6'd11
  } alu_op_e;

  // A bubble is an add with no side effects; data and address fields clear to zero.
  localparam logic    BUBBLE_VALID = 1'b0;
  localparam logic    BUBBLE_CTRL  = 1'b0;
  localparam alu_op_e BUBBLE_OP    = ALU_ADD;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select for one source register: EX/MEM result beats
// MEM/WB result beats register-file data; register 0 is never forwarded.
module fwd_mux #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0]     reg_data,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
  input  logic [DATA_W-1:0]     exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
  input  logic [DATA_W-1:0]     memwb_result,
  output logic [DATA_W-1:0]     fwd_data
);

  always_comb begin
    fwd_data = reg_data;
    if (exmem_reg_write && (exmem_rd_addr != '0) && (exmem_rd_addr == src_addr))
      fwd_data = exmem_result;
    else if (memwb_reg_write && (memwb_rd_addr != '0) && (memwb_rd_addr == src_addr))
      fwd_data = memwb_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded fields, forwards operands into
// the ALU inputs and inserts bubbles on flush or load-use hazards.
module id_ex_stage #(
  parameter int unsigned DATA_W     = pipeline_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = pipeline_pkg::REG_ADDR_W,
  parameter int unsigned OP_W       = pipeline_pkg::OP_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_in,
  input  logic                  flush_in,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic [OP_W-1:0]       id_alu_op,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
  input  logic [DATA_W-1:0]     exmem_result,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
  input  logic [DATA_W-1:0]     memwb_result,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_op1,
  output logic [DATA_W-1:0]     ex_op2,
  output logic [OP_W-1:0]       ex_operation,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [DATA_W-1:0]     ex_pc,
  output logic                  load_use_stall
);

  import pipeline_pkg::*;

  logic                  r_valid;
  logic [DATA_W-1:0]     r_pc;
  logic [DATA_W-1:0]     r_rs_data;
  logic [DATA_W-1:0]     r_rt_data;
  logic [DATA_W-1:0]     r_imm;
  logic [REG_ADDR_W-1:0] r_rs_addr;
  logic [REG_ADDR_W-1:0] r_rt_addr;
  logic [REG_ADDR_W-1:0] r_rd_addr;
  logic [OP_W-1:0]       r_op;
  logic                  r_alu_src;
  logic                  r_reg_write;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [DATA_W-1:0]     fwd_rs;
  logic [DATA_W-1:0]     fwd_rt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= '0;
      r_pc        <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rd_addr   <= '0;
      r_op        <= '0;
      r_alu_src   <= '0;
      r_reg_write <= '0;
      r_mem_read  <= '0;
      r_mem_write <= '0;
    end else if (!stall_in) begin
      if (flush_in || load_use_stall) begin
        r_valid     <= BUBBLE_VALID;
        r_pc        <= '0;
        r_rs_data   <= '0;
        r_rt_data   <= '0;
        r_imm       <= '0;
        r_rs_addr   <= '0;
        r_rt_addr   <= '0;
        r_rd_addr   <= '0;
        r_op        <= OP_W'(BUBBLE_OP);
        r_alu_src   <= BUBBLE_CTRL;
        r_reg_write <= BUBBLE_CTRL;
        r_mem_read  <= BUBBLE_CTRL;
        r_mem_write <= BUBBLE_CTRL;
      end else begin
        r_valid     <= id_valid;
        r_pc        <= id_pc;
        r_rs_data   <= id_rs_data;
        r_rt_data   <= id_rt_data;
        r_imm       <= id_imm;
        r_rs_addr   <= id_rs_addr;
        r_rt_addr   <= id_rt_addr;
        r_rd_addr   <= id_rd_addr;
        r_op        <= id_alu_op;
        r_alu_src   <= id_alu_src;
        r_reg_write <= id_reg_write;
        r_mem_read  <= id_mem_read;
        r_mem_write <= id_mem_write;
      end
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .src_addr        (r_rs_addr),
    .reg_data        (r_rs_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rs)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .src_addr        (r_rt_addr),
    .reg_data        (r_rt_data),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd_addr   (exmem_rd_addr),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd_addr   (memwb_rd_addr),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_rt)
  );

  assign ex_valid      = r_valid;
  assign ex_pc         = r_pc;
  assign ex_operation  = r_op;
  assign ex_rd_addr    = r_rd_addr;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_op1        = fwd_rs;
  assign ex_op2        = r_alu_src ? r_imm : fwd_rt;
  assign ex_store_data = fwd_rt;

  // rt is compared even for immediate-format instructions; the extra stall is accepted.
  assign load_use_stall = r_valid && r_mem_read && (r_rd_addr != '0) && id_valid &&
                          ((id_rs_addr == r_rd_addr) || (id_rt_addr == r_rd_addr));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: scenario tasks push expectations into
// a scoreboard queue and pop them when the EX outputs are sampled.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  logic        clk, rst, stall_in, flush_in;
  logic        id_valid;
  logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [5:0]  id_alu_op;
  logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd_addr, memwb_rd_addr;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;
  logic [31:0] ex_op1, ex_op2, ex_store_data, ex_pc;
  logic [5:0]  ex_operation;
  logic [4:0]  ex_rd_addr;

  typedef struct {
    logic        valid;
    logic [31:0] op1, op2, store, pc;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic        rw, mr, mw;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush_in(flush_in),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_operation(ex_operation),
    .ex_store_data(ex_store_data), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_pc(ex_pc),
    .load_use_stall(load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_fwd(input logic [4:0] a, input logic [31:0] d,
                                            input logic xw, input logic [4:0] xa, input logic [31:0] xr,
                                            input logic ww, input logic [4:0] wa, input logic [31:0] wr);
    if (xw && xa != 5'd0 && xa == a) return xr;
    if (ww && wa != 5'd0 && wa == a) return wr;
    return d;
  endfunction

  task automatic idle_inputs();
    stall_in = 0; flush_in = 0;
    id_valid = 0; id_pc = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs_addr = '0; id_rt_addr = '0; id_rd_addr = '0; id_alu_op = '0;
    id_alu_src = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    exmem_reg_write = 0; exmem_rd_addr = '0; exmem_result = '0;
    memwb_reg_write = 0; memwb_rd_addr = '0; memwb_result = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    id_valid = 1; id_pc = 32'h44; id_rs_data = 32'h9; id_reg_write = 1; id_alu_op = 6'd5;
    rst = 1;
    step();
    step();
    sb.push_back('{valid:0, op1:0, op2:0, store:0, pc:0, op:6'(ALU_ADD), rd:0, rw:0, mr:0, mw:0});
    e = sb.pop_front();
    checks++;
    if ({ex_valid, ex_pc, ex_operation, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write} !==
        {e.valid, e.pc, e.op, e.rd, e.rw, e.mr, e.mw}) begin
      errors++;
      $display("FAIL reset_ctrl: got v=%b pc=%h op=%0d rd=%0d ctl=%b%b%b expected all zero",
               ex_valid, ex_pc, ex_operation, ex_rd_addr, ex_reg_write, ex_mem_read, ex_mem_write);
    end
    checks++;
    if ({ex_op1, ex_op2, ex_store_data, load_use_stall} !== {e.op1, e.op2, e.store, 1'b0}) begin
      errors++;
      $display("FAIL reset_data: got op1=%h op2=%h st=%h lus=%b expected zeros",
               ex_op1, ex_op2, ex_store_data, load_use_stall);
    end
    idle_inputs();
    rst = 0;
  endtask

  task automatic test_capture();
    idle_inputs();
    id_valid = 1; id_pc = 32'h100; id_rs_data = 32'd3; id_rt_data = 32'd2;
    id_rs_addr = 5'd1; id_rt_addr = 5'd2; id_rd_addr = 5'd3;
    id_alu_op = 6'(ALU_SUB); id_reg_write = 1;
    sb.push_back('{valid:1, op1:32'd3, op2:32'd2, store:32'd2, pc:32'h100, op:6'd1, rd:5'd3, rw:1, mr:0, mw:0});
    step();
    e = sb.pop_front();
    checks++;
    if ({ex_valid, ex_op1, ex_op2, ex_operation} !== {e.valid, e.op1, e.op2, e.op}) begin
      errors++;
      $display("FAIL capture_alu: got v=%b op1=%h op2=%h op=%0d expected v=%b op1=%h op2=%h op=%0d",
               ex_valid, ex_op1, ex_op2, ex_operation, e.valid, e.op1, e.op2, e.op);
    end
    checks++;
    if ({ex_pc, ex_rd_addr, ex_store_data, ex_reg_write, ex_mem_read, ex_mem_write} !==
        {e.pc, e.rd, e.store, e.rw, e.mr, e.mw}) begin
      errors++;
      $display("FAIL capture_fields: got pc=%h rd=%0d st=%h ctl=%b%b%b expected pc=%h rd=%0d st=%h ctl=%b%b%b",
               ex_pc, ex_rd_addr, ex_store_data, ex_reg_write, ex_mem_read, ex_mem_write,
               e.pc, e.rd, e.store, e.rw, e.mr, e.mw);
    end
  endtask

  task automatic test_forward_priority();
    idle_inputs();
    id_valid = 1; id_rs_addr = 5'd5; id_rs_data = 32'hAAAA; id_rd_addr = 5'd6;
    step();
    exmem_reg_write = 1; exmem_rd_addr = 5'd5; exmem_result = 32'h10;
    memwb_reg_write = 1; memwb_rd_addr = 5'd5; memwb_result = 32'h20;
    sb.push_back('{valid:1, op1:32'h10, op2:0, store:0, pc:0, op:0, rd:5'd6, rw:0, mr:0, mw:0});
    #1;
    e = sb.pop_front();
    checks++;
    if (ex_op1 !== e.op1) begin
      errors++;
      $display("FAIL fwd_exmem_wins: got %h expected %h", ex_op1, e.op1);
    end
    exmem_reg_write = 0;
    sb.push_back('{valid:1, op1:32'h20, op2:0, store:0, pc:0, op:0, rd:5'd6, rw:0, mr:0, mw:0});
    #1;
    e = sb.pop_front();
    checks++;
    if (ex_op1 !== e.op1) begin
      errors++;
      $display("FAIL fwd_memwb: got %h expected %h", ex_op1, e.op1);
    end
    exmem_reg_write = 1; exmem_rd_addr = 5'd0; memwb_rd_addr = 5'd0;
    sb.push_back('{valid:1, op1:32'hAAAA, op2:0, store:0, pc:0, op:0, rd:5'd6, rw:0, mr:0, mw:0});
    #1;
    e = sb.pop_front();
    checks++;
    if (ex_op1 !== e.op1) begin
      errors++;
      $display("FAIL fwd_r0_blocked: got %h expected %h", ex_op1, e.op1);
    end
  endtask

  task automatic test_imm_select();
    idle_inputs();
    id_valid = 1; id_alu_src = 1; id_imm = 32'hFFFFFC18;
    id_rt_addr = 5'd4; id_rt_data = 32'h99; id_rs_addr = 5'd2; id_rs_data = 32'h5;
    id_alu_op = 6'(ALU_ADD); id_mem_write = 1;
    memwb_reg_write = 1; memwb_rd_addr = 5'd4; memwb_result = 32'h7;
    sb.push_back('{valid:1, op1:32'h5, op2:32'hFFFFFC18, store:32'h7, pc:0, op:0, rd:0, rw:0, mr:0, mw:1});
    step();
    e = sb.pop_front();
    checks++;
    if ({ex_op1, ex_op2, ex_store_data, ex_mem_write} !== {e.op1, e.op2, e.store, e.mw}) begin
      errors++;
      $display("FAIL imm_select: got op1=%h op2=%h st=%h mw=%b expected op1=%h op2=%h st=%h mw=%b",
               ex_op1, ex_op2, ex_store_data, ex_mem_write, e.op1, e.op2, e.store, e.mw);
    end
  endtask

  task automatic test_load_use();
    idle_inputs();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd_addr = 5'd7;
    id_rs_addr = 5'd1; id_rt_addr = 5'd2; id_pc = 32'h300;
    step();
    idle_inputs();
    id_valid = 1; id_rs_addr = 5'd7; id_rt_addr = 5'd3; id_rd_addr = 5'd8;
    id_rs_data = 32'h55; id_alu_op = 6'(ALU_MUL); id_reg_write = 1; id_pc = 32'h304;
    #1;
    checks++;
    if (load_use_stall !== 1'b1) begin
      errors++;
      $display("FAIL load_use_detect: got %b expected 1", load_use_stall);
    end
    sb.push_back('{valid:0, op1:0, op2:0, store:0, pc:0, op:0, rd:0, rw:0, mr:0, mw:0});
    step();
    e = sb.pop_front();
    checks++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_operation, ex_pc, ex_op1} !==
        {e.valid, e.rw, e.mr, e.op, e.pc, e.op1}) begin
      errors++;
      $display("FAIL load_use_bubble: got v=%b rw=%b mr=%b op=%0d pc=%h op1=%h expected bubble",
               ex_valid, ex_reg_write, ex_mem_read, ex_operation, ex_pc, ex_op1);
    end
    checks++;
    if (load_use_stall !== 1'b0) begin
      errors++;
      $display("FAIL load_use_clear: got %b expected 0", load_use_stall);
    end
    sb.push_back('{valid:1, op1:32'h55, op2:0, store:0, pc:32'h304, op:6'd2, rd:5'd8, rw:1, mr:0, mw:0});
    step();
    e = sb.pop_front();
    checks++;
    if ({ex_valid, ex_op1, ex_operation, ex_rd_addr, ex_pc, ex_reg_write} !==
        {e.valid, e.op1, e.op, e.rd, e.pc, e.rw}) begin
      errors++;
      $display("FAIL load_use_recapture: got v=%b op1=%h op=%0d rd=%0d pc=%h expected v=%b op1=%h op=%0d rd=%0d pc=%h",
               ex_valid, ex_op1, ex_operation, ex_rd_addr, ex_pc, e.valid, e.op1, e.op, e.rd, e.pc);
    end
  endtask

  task automatic test_stall_flush();
    idle_inputs();
    id_valid = 1; id_pc = 32'h400; id_rs_addr = 5'd3; id_rs_data = 32'h11;
    id_rd_addr = 5'd4; id_alu_op = 6'(ALU_XOR); id_reg_write = 1;
    step();
    stall_in = 1; flush_in = 1;
    id_pc = 32'h500; id_rs_data = 32'hBAD; id_rd_addr = 5'd12; id_alu_op = 6'(ALU_OR);
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{valid:1, op1:32'h11, op2:0, store:0, pc:32'h400, op:6'd9, rd:5'd4, rw:1, mr:0, mw:0});
      step();
      e = sb.pop_front();
      checks++;
      if ({ex_valid, ex_pc, ex_op1, ex_operation, ex_rd_addr, ex_reg_write} !==
          {e.valid, e.pc, e.op1, e.op, e.rd, e.rw}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b pc=%h op1=%h op=%0d rd=%0d expected v=%b pc=%h op1=%h op=%0d rd=%0d",
                 i, ex_valid, ex_pc, ex_op1, ex_operation, ex_rd_addr, e.valid, e.pc, e.op1, e.op, e.rd);
      end
    end
    stall_in = 0;
    sb.push_back('{valid:0, op1:0, op2:0, store:0, pc:0, op:0, rd:0, rw:0, mr:0, mw:0});
    step();
    e = sb.pop_front();
    checks++;
    if ({ex_valid, ex_pc, ex_op1, ex_operation, ex_rd_addr, ex_reg_write} !==
        {e.valid, e.pc, e.op1, e.op, e.rd, e.rw}) begin
      errors++;
      $display("FAIL flush_bubble: got v=%b pc=%h op1=%h op=%0d rd=%0d rw=%b expected bubble",
               ex_valid, ex_pc, ex_op1, ex_operation, ex_rd_addr, ex_reg_write);
    end
    flush_in = 0;
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    id_valid = 1; id_pc = 32'h200; id_rs_addr = 5'd2; id_rs_data = 32'h33;
    id_rd_addr = 5'd9; id_alu_op = 6'(ALU_SLT); id_reg_write = 1;
    step();
    #2 rst = 1;
    sb.push_back('{valid:0, op1:0, op2:0, store:0, pc:0, op:0, rd:0, rw:0, mr:0, mw:0});
    #1;
    e = sb.pop_front();
    checks++;
    if ({ex_valid, ex_pc, ex_op1, ex_operation, ex_rd_addr, ex_reg_write} !==
        {e.valid, e.pc, e.op1, e.op, e.rd, e.rw}) begin
      errors++;
      $display("FAIL async_reset: got v=%b pc=%h op1=%h op=%0d rd=%0d rw=%b expected zeros",
               ex_valid, ex_pc, ex_op1, ex_operation, ex_rd_addr, ex_reg_write);
    end
    #1 rst = 0;
    sb.push_back('{valid:1, op1:32'h33, op2:0, store:0, pc:32'h200, op:6'd6, rd:5'd9, rw:1, mr:0, mw:0});
    step();
    e = sb.pop_front();
    checks++;
    if ({ex_valid, ex_pc, ex_op1, ex_operation, ex_rd_addr, ex_reg_write} !==
        {e.valid, e.pc, e.op1, e.op, e.rd, e.rw}) begin
      errors++;
      $display("FAIL post_reset_capture: got v=%b pc=%h op1=%h op=%0d rd=%0d expected v=%b pc=%h op1=%h op=%0d rd=%0d",
               ex_valid, ex_pc, ex_op1, ex_operation, ex_rd_addr, e.valid, e.pc, e.op1, e.op, e.rd);
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int i = 0; i < 24; i++) begin
      id_valid = 1'($urandom_range(0, 1));
      id_pc = $urandom; id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_rs_addr = 5'($urandom_range(0, 3)); id_rt_addr = 5'($urandom_range(0, 3));
      id_rd_addr = 5'($urandom_range(0, 31));
      id_alu_op = 6'($urandom_range(0, 63));
      id_alu_src = 1'($urandom_range(0, 1));
      id_reg_write = 1'($urandom_range(0, 1)); id_mem_write = 1'($urandom_range(0, 1));
      exmem_reg_write = 1'($urandom_range(0, 1)); exmem_rd_addr = 5'($urandom_range(0, 3));
      exmem_result = $urandom;
      memwb_reg_write = 1'($urandom_range(0, 1)); memwb_rd_addr = 5'($urandom_range(0, 3));
      memwb_result = $urandom;
      e.valid = id_valid; e.pc = id_pc; e.op = id_alu_op; e.rd = id_rd_addr;
      e.rw = id_reg_write; e.mr = 0; e.mw = id_mem_write;
      e.op1 = model_fwd(id_rs_addr, id_rs_data, exmem_reg_write, exmem_rd_addr, exmem_result,
                        memwb_reg_write, memwb_rd_addr, memwb_result);
      e.store = model_fwd(id_rt_addr, id_rt_data, exmem_reg_write, exmem_rd_addr, exmem_result,
                          memwb_reg_write, memwb_rd_addr, memwb_result);
      e.op2 = id_alu_src ? id_imm : e.store;
      sb.push_back(e);
      step();
      e = sb.pop_front();
      checks++;
      if ({ex_valid, ex_pc, ex_operation, ex_rd_addr, ex_reg_write, ex_mem_write} !==
          {e.valid, e.pc, e.op, e.rd, e.rw, e.mw}) begin
        errors++;
        $display("FAIL b2b_fields[%0d]: got v=%b pc=%h op=%0d rd=%0d rw=%b mw=%b expected v=%b pc=%h op=%0d rd=%0d rw=%b mw=%b",
                 i, ex_valid, ex_pc, ex_operation, ex_rd_addr, ex_reg_write, ex_mem_write,
                 e.valid, e.pc, e.op, e.rd, e.rw, e.mw);
      end
      checks++;
      if ({ex_op1, ex_op2, ex_store_data} !== {e.op1, e.op2, e.store}) begin
        errors++;
        $display("FAIL b2b_operands[%0d]: got op1=%h op2=%h st=%h expected op1=%h op2=%h st=%h",
                 i, ex_op1, ex_op2, ex_store_data, e.op1, e.op2, e.store);
      end
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_capture();
    test_forward_priority();
    test_imm_select();
    test_load_use();
    test_stall_flush();
    test_reset_mid();
    test_back_to_back();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
